// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Merges two issue-lane writebacks and a buffered long-latency
//            result stream onto two registered register-file write ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        l0_valid,
    input  logic [4:0]  l0_rd,
    input  logic [31:0] l0_data,
    input  logic        l1_valid,
    input  logic [4:0]  l1_rd,
    input  logic [31:0] l1_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        we1,
    output logic [4:0]  wr_reg1,
    output logic [31:0] wr_data1,
    output logic        we2,
    output logic [4:0]  wr_reg2,
    output logic [31:0] wr_data2,
    output logic [31:0] pend_mask
);

    localparam logic [1:0] c_CNT_FULL = 2'd2;

    // Two-entry FIFO kept as a shift pair: entry 0 is always the head.
    logic [1:0]  r_cnt;
    logic [4:0]  r_rd0, r_rd1;
    logic [31:0] r_data0, r_data1;

    logic        w_push;
    logic        w_l0_wr, w_l1_wr;
    logic [1:0]  w_lane_n, w_slots;
    logic        w_h_vld, w_s_vld;
    logic        w_h_drop, w_s_drop, w_h_dup;
    logic        w_h_disc, w_h_wr, w_h_pop;
    logic        w_s_room, w_s_wr, w_s_pop;
    logic [1:0]  w_cnt_pop, w_cnt_nxt;
    logic [4:0]  w_rd0_nxt, w_rd1_nxt;
    logic [31:0] w_data0_nxt, w_data1_nxt;

    logic [3:0]        w_c_en;
    logic [3:0][4:0]   w_c_rd;
    logic [3:0][31:0]  w_c_data;
    logic              w_p1_en, w_p2_en;
    logic [4:0]        w_p1_rd, w_p2_rd;
    logic [31:0]       w_p1_data, w_p2_data;

    assign lu_ready = rst & (r_cnt != c_CNT_FULL);
    assign w_push   = lu_valid & lu_ready;

    // Lane survivors: rd 0 is dropped, and l0 loses a same-cycle WAW to l1.
    assign w_l0_wr  = l0_valid & (l0_rd != 5'd0) & ~(l1_valid & (l1_rd == l0_rd));
    assign w_l1_wr  = l1_valid & (l1_rd != 5'd0);
    assign w_lane_n = {1'b0, w_l0_wr} + {1'b0, w_l1_wr};
    assign w_slots  = 2'd2 - w_lane_n;

    assign w_h_vld  = (r_cnt != 2'd0);
    assign w_s_vld  = (r_cnt == c_CNT_FULL);

    // A buffered result is stale if it targets x0 or a lane writes the same rd.
    assign w_h_drop = (r_rd0 == 5'd0) | (l0_valid & (l0_rd == r_rd0)) | (l1_valid & (l1_rd == r_rd0));
    assign w_s_drop = (r_rd1 == 5'd0) | (l0_valid & (l0_rd == r_rd1)) | (l1_valid & (l1_rd == r_rd1));

    // Head is superseded by an equal-rd second entry whenever a port is free to
    // drain both, which also keeps the two ports from ever sharing an rd.
    assign w_h_dup  = w_s_vld & (r_rd0 == r_rd1) & ~w_s_drop & (w_slots != 2'd0);
    assign w_h_disc = w_h_vld & (w_h_drop | w_h_dup);
    assign w_h_wr   = w_h_vld & ~w_h_disc & (w_slots != 2'd0);
    assign w_h_pop  = w_h_disc | w_h_wr;

    assign w_s_room = (w_slots == 2'd2) | ((w_slots == 2'd1) & ~w_h_wr);
    assign w_s_wr   = w_s_vld & ~w_s_drop & w_h_pop & w_s_room;
    assign w_s_pop  = w_h_pop & w_s_vld & (w_s_drop | w_s_wr);

    assign w_c_en   = {w_s_wr, w_h_wr, w_l1_wr, w_l0_wr};
    assign w_c_rd   = {r_rd1, r_rd0, l1_rd, l0_rd};
    assign w_c_data = {r_data1, r_data0, l1_data, l0_data};

    always_comb begin
        w_p1_en   = 1'b0;
        w_p1_rd   = 5'd0;
        w_p1_data = 32'd0;
        w_p2_en   = 1'b0;
        w_p2_rd   = 5'd0;
        w_p2_data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_c_en[i]) begin
                if (!w_p1_en) begin
                    w_p1_en   = 1'b1;
                    w_p1_rd   = w_c_rd[i];
                    w_p1_data = w_c_data[i];
                end else if (!w_p2_en) begin
                    w_p2_en   = 1'b1;
                    w_p2_rd   = w_c_rd[i];
                    w_p2_data = w_c_data[i];
                end
            end
        end
    end

    always_comb begin
        w_cnt_pop   = r_cnt - {1'b0, w_h_pop} - {1'b0, w_s_pop};
        w_rd0_nxt   = r_rd0;
        w_data0_nxt = r_data0;
        w_rd1_nxt   = r_rd1;
        w_data1_nxt = r_data1;
        if (w_h_pop && !w_s_pop) begin
            w_rd0_nxt   = r_rd1;
            w_data0_nxt = r_data1;
        end
        if (w_push) begin
            if (w_cnt_pop == 2'd0) begin
                w_rd0_nxt   = lu_rd;
                w_data0_nxt = lu_data;
            end else begin
                w_rd1_nxt   = lu_rd;
                w_data1_nxt = lu_data;
            end
        end
        w_cnt_nxt = w_cnt_pop + {1'b0, w_push};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 2'd0;
            r_rd0    <= 5'd0;
            r_rd1    <= 5'd0;
            r_data0  <= 32'd0;
            r_data1  <= 32'd0;
            we1      <= 1'b0;
            wr_reg1  <= 5'd0;
            wr_data1 <= 32'd0;
            we2      <= 1'b0;
            wr_reg2  <= 5'd0;
            wr_data2 <= 32'd0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_rd0    <= w_rd0_nxt;
            r_rd1    <= w_rd1_nxt;
            r_data0  <= w_data0_nxt;
            r_data1  <= w_data1_nxt;
            we1      <= w_p1_en;
            wr_reg1  <= w_p1_rd;
            wr_data1 <= w_p1_data;
            we2      <= w_p2_en;
            wr_reg2  <= w_p2_rd;
            wr_data2 <= w_p2_data;
        end
    end

    always_comb begin
        pend_mask = 32'd0;
        if (w_h_vld && (r_rd0 != 5'd0)) pend_mask[r_rd0] = 1'b1;
        if (w_s_vld && (r_rd1 != 5'd0)) pend_mask[r_rd1] = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-low.
REQ-003: l0_valid, l0_rd, l0_data  input  1/5/32  issue-lane-0 writeback (older instruction of the pair).
REQ-004: l1_valid, l1_rd, l1_data  input  1/5/32  issue-lane-1 writeback (younger instruction of the pair).
REQ-005: lu_valid, lu_rd, lu_data  input  1/5/32  long-latency unit (load/mul) result request.
REQ-006: lu_ready  output  1  long-latency result accepted this cycle when lu_valid && lu_ready.
REQ-007: we1, wr_reg1, wr_data1  output  1/5/32  register file write port 1.
REQ-008: we2, wr_reg2, wr_data2  output  1/5/32  register file write port 2.
REQ-009: pend_mask  output  32  bit n set while a buffered long-latency result targets register n.

Function
REQ-010: Block SHALL hold a 2-entry in-order FIFO (rd, data) for long-latency results; lu_ready = FIFO not full (combinational from state).
REQ-011: Accepted lu results SHALL enter the FIFO tail; they are never written in the cycle of acceptance.
REQ-012: Lane writebacks SHALL never be stalled or buffered; they always have priority over FIFO entries.
REQ-013: Any candidate with rd == 0 SHALL be discarded (FIFO entry popped, no write).
REQ-014: WAW within a cycle: if l0 and l1 are both valid with equal rd, l0 SHALL be discarded.
REQ-015: If a FIFO entry's rd equals a valid lane rd in the same cycle, that entry SHALL be popped and discarded (lane data is newer).
REQ-016: If both FIFO entries are drained in one cycle with equal rd, the head SHALL be discarded and only the second written.
REQ-017: Surviving candidates SHALL be ordered l0, l1, FIFO head, FIFO second; first survivor to port 1, second to port 2; the rest wait.
REQ-018: FIFO entries SHALL pop only when written or discarded; up to 2 pops per cycle; a push and pops in the same cycle are both honoured.
REQ-019: Port outputs SHALL be registered: a candidate presented in cycle N appears on we/wr_reg/wr_data in cycle N+1 (register file samples on the following falling edge).
REQ-020: we2 SHALL never be asserted while we1 is low; wr_reg1 and wr_reg2 SHALL never be equal while both enables are high.
REQ-021: When an enable is low, the matching wr_reg/wr_data SHALL be driven 0.
REQ-022: pend_mask SHALL be the OR of the one-hot rd of valid FIFO entries (rd 0 excluded), updated with FIFO state.

Reset
REQ-023: While rst is low: FIFO empty, we1=we2=0, wr_reg*=0, wr_data*=0, pend_mask=0, lu_ready=0.
REQ-024: lu_ready SHALL rise in the first cycle after rst deasserts; reset mid-operation SHALL drop buffered entries without writing them.

Verification
REQ-025: l0(rd=5,0xA) and l1(rd=6,0xB) valid -> next cycle we1=1 reg5=0xA, we2=1 reg6=0xB.
REQ-026: l0 and l1 both rd=7 (0x1, 0x2) -> next cycle we1=1 reg7=0x2, we2=0.
REQ-027: lu push rd=9 0xC while both lanes busy for 2 cycles, then lanes idle -> pend_mask[9]=1 while buffered, write of reg9=0xC on port 1 the cycle after lanes go idle; pend_mask[9] then 0.
REQ-028: Two lu pushes with lanes busy -> lu_ready=0 (FIFO full); third lu_valid held until a pop, then accepted.
REQ-029: FIFO head rd=3, l1 rd=3 same cycle -> only lane value written to reg3; head popped.
REQ-030: rst low while FIFO holds 2 entries -> all outputs 0; after release, no stale write occurs and lu_ready=1.
